// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port among NUM_REQ byte producers.
// A grant covers one message, ending at req_last, at req drop, or at MAX_BURST accepted bytes.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             ack,
    output logic [$clog2(NUM_REQ)-1:0]     owner,
    output logic                           busy,
    output logic [DATA_SIZE-1:0]           fifo_data,
    output logic                           fifo_write,
    input  logic                           fifo_full
);

    localparam int unsigned OW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t              state, state_nxt;
    logic [OW-1:0]       owner_nxt;
    logic [OW-1:0]       rr_ptr, rr_ptr_nxt;
    logic [CW-1:0]       burst_cnt, burst_cnt_nxt;
    logic [OW-1:0]       pick;
    logic                pick_valid;
    logic [OW-1:0]       cand;
    logic                accept;
    logic                release_own;
    logic [DATA_SIZE-1:0] data_arr [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    // First requester strictly after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = OW'((32'(rr_ptr) + i) % NUM_REQ);
            if (!pick_valid && req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Reset gates the write so nothing reaches the FIFO in the reset cycle.
    assign accept = (state == OWN) && req[owner] && !fifo_full && !reset;

    assign release_own = (state == OWN) &&
                         (!req[owner] ||
                          (accept && (req_last[owner] || burst_cnt == CW'(MAX_BURST - 1))));

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    owner_nxt     = pick;
                    burst_cnt_nxt = '0;
                    state_nxt     = OWN;
                end
            end
            OWN: begin
                if (accept && burst_cnt != CW'(MAX_BURST)) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end
                if (release_own) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = owner;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= OW'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    always_comb begin
        grant      = '0;
        ack        = '0;
        fifo_write = accept;
        fifo_data  = '0;
        busy       = (state == OWN);
        if (state == OWN) begin
            grant[owner] = 1'b1;
            fifo_data    = data_arr[owner];
        end
        if (accept) begin
            ack[owner] = 1'b1;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit FIFO (`uart_fifo` feeding `uart_transmitter`) among several on-chip byte producers. Each requester obtains exclusive ownership for a message and streams bytes with a per-byte ack. Ownership is released at end of message, when the requester abandons it, or at a burst limit that forces fairness. Sits on the system clock domain between the requesters and the TX FIFO `write`/`data_in`/`full` port.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `DATA_SIZE`, default 8: byte width; must match the TX FIFO.
- `MAX_BURST`, default 16: maximum bytes accepted per grant before forced release (1..255).
- `clk`  in  1  system clock; same clock as the TX FIFO.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request; held high while the requester has a byte to send.
- `req_data`  in  NUM_REQ*DATA_SIZE  byte of requester i in bits [i*DATA_SIZE +: DATA_SIZE].
- `req_last`  in  NUM_REQ  marks the presented byte as the last of the message.
- `grant`  out  NUM_REQ  one-hot ownership; all-zero when idle.
- `ack`  out  NUM_REQ  one-cycle pulse: presented byte was written to the FIFO this cycle.
- `owner`  out  $clog2(NUM_REQ)  index of current owner; valid while `busy`.
- `busy`  out  1  high while any grant is held.
- `fifo_data`  out  DATA_SIZE  connects to TX FIFO `data_in`.
- `fifo_write`  out  1  connects to TX FIFO `write`.
- `fifo_full`  in  1  connects to TX FIFO `full`.

## Operation
- Two states: IDLE, OWN.
- IDLE: if any `req` is high, choose the first requesting index strictly after `rr_ptr`, searching upward modulo NUM_REQ. Register it into `owner`, set `grant[owner]`, clear `burst_cnt`, and go to OWN. If no request, stay in IDLE.
- OWN: `accept = req[owner] & ~fifo_full`.
  - `fifo_write = accept`; `fifo_data = req_data[owner]` (combinational mux, 0 when IDLE).
  - `ack[owner] = accept`; all other `ack` bits are 0.
- Each accept increments `burst_cnt`. The counter width is $clog2(MAX_BURST+1) and it never wraps.
- Release from OWN to IDLE happens on the clock edge that ends a cycle in which any of these holds:
  - accept & `req_last[owner]` (end of message);
  - accept & `burst_cnt == MAX_BURST-1` (forced rotation);
  - `req[owner]` low (abandon; no write that cycle).
- On release: `rr_ptr <= owner` and `grant` is cleared. The next arbitration therefore starts after the previous owner.
- `fifo_full` high in OWN: no write, no ack, ownership kept, counter unchanged (back-pressure stall, unbounded).
- Changes to `req`/`req_data` of non-owners during OWN are ignored.
- `busy = (state == OWN)`.

## Timing
- Reset values: state IDLE, `grant` 0, `ack` 0, `busy` 0, `owner` 0, `fifo_write` 0, `fifo_data` 0, `burst_cnt` 0. `rr_ptr` = NUM_REQ-1, so requester 0 wins first.
- Grant latency: `req` sampled high in IDLE at edge N gives `grant` high after edge N. The first accept can occur in that same cycle.
- Throughput: one byte per clock while the owner holds `req` and the FIFO is not full.
- Requester handshake:
  - Present byte and `req_last` while `req` is high.
  - On the cycle with `ack` high, the byte is consumed.
  - Present the next byte, or drop `req`, after that edge.
- Re-arbitration gap: exactly one IDLE cycle between consecutive grants, even for the same requester.
- Forced rotation with a sole requester: that requester is regranted after the one IDLE cycle.
- `fifo_full` rising and `req_last` in the same cycle: no accept, so no release. `req_last` takes effect only with an accept.
- Reset asserted during OWN: at the next edge all outputs return to reset values. A partially sent message is abandoned; no write occurs in the reset cycle.

## Test plan
- Reset then single message: `req[2]` with bytes 0xB3, 0x5C, `req_last` on 0x5C.
  - `grant` = 4'b0100 one cycle after request.
  - FIFO receives 0xB3 then 0x5C on consecutive cycles, with two `ack[2]` pulses.
  - Then `busy` = 0.
- Round-robin fairness: `req` = 4'b1111 continuously, each sending 1-byte messages (`req_last` = 1).
  - Grant order is 0, 1, 2, 3, 0, …
  - One IDLE cycle between grants.
- Burst limit with MAX_BURST = 4: requester 1 streams 10 bytes with no `req_last` while requester 3 also requests.
  - After 4 accepts, the grant moves to 3.
  - Requester 1 resumes only after 3 releases; its byte order is preserved in the FIFO.
- Back-pressure: `fifo_full` held high for 20 cycles mid-message.
  - No `fifo_write` and no `ack` during the stall.
  - Grant is held.
  - Transfer resumes with the same byte (e.g. 0xAE) when full drops.
- Abandon and reset: owner drops `req` mid-message, which releases with no write. Then assert `reset` during an active grant.
  - Next cycle: `grant` = 0, `busy` = 0, `fifo_write` = 0.
  - The first arbitration after reset grants requester 0.
- Sole requester at burst limit (MAX_BURST = 2): requester 0 streams 5 bytes.
  - Pattern is 2 accepts, 1 idle, 2 accepts, 1 idle, 1 accept.
  - Exactly 5 FIFO writes in order.
